// File: rtl/pipelined_adder_pkg.sv
// Shared arithmetic helpers for the pipelined ripple-carry adder.
// Latency: n/a (pure functions).
// Backpressure: n/a.
//
// Contents: half-adder sum/carry, full adder composed from two half adders,
// and the slice-width helper used to split operands across pipeline stages.
package pipelined_adder_pkg;

    // Bits handled per pipeline stage.
    function automatic int slice_width(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic logic hasum(input logic a, input logic b);
        return a ^ b;
    endfunction

    function automatic logic hacarry(input logic a, input logic b);
        return a & b;
    endfunction

    // Returns {carry, sum}; two half adders plus an OR of their carries.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        logic s1;
        logic c1;
        logic c2;
        s1 = hasum(a, b);
        c1 = hacarry(a, b);
        c2 = hacarry(s1, c);
        return {c1 | c2, hasum(s1, c)};
    endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational W-bit ripple-carry slice built from per-bit full adders.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; the enclosing pipeline stage decides when to capture.
//
// Ports: a_i, b_i (W bits), cin_i -> sum_o (W bits), cout_o.
module adder_slice
    import pipelined_adder_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o
);

    logic carry;

    always_comb begin
        sum_o = '0;
        carry = cin_i;
        for (int i = 0; i < W; i++) begin
            {carry, sum_o[i]} = full_add(a_i[i], b_i[i], carry);
        end
        cout_o = carry;
    end

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder: one SLICE_W-bit slice added per stage, carry registered between stages.
// Latency: STAGES cycles from input acceptance to out_valid; throughput 1 beat/cycle.
// Backpressure: combinational ready chain; a stage advances when it is empty or its successor advances.
//
// Ports: clk, rst_n (async, active-low); in_valid/in_ready/in_a/in_b/in_cin input beat;
//        out_valid/out_ready/out_sum/out_cout result beat.
// Optional macro PIPE_ADDER_SUB_EN adds in_sub: 1 computes A + ~B + 1 (in_cin ignored),
//        so out_cout=1 means no borrow.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout
);

    localparam int SW = slice_width(WIDTH, STAGES);

    if (WIDTH % STAGES != 0) begin : g_bad_cfg
        $error("pipelined_adder: WIDTH must be a multiple of STAGES");
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        // Operand bits not yet consumed when they arrive at this stage.
        localparam int IW = WIDTH - g * SW;

        logic                v_q;
        logic [(g+1)*SW-1:0] sum_q;
        logic [(g+1)*SW-1:0] sum_d;
        logic                c_q;
        logic                rdy;
        logic                rdy_next;

        logic                v_prev;
        logic                c_prev;
        logic [IW-1:0]       a_prev;
        logic [IW-1:0]       b_prev;
        logic [SW-1:0]       b_eff;
        logic [SW-1:0]       s_sum;
        logic                s_cout;
`ifdef PIPE_ADDER_SUB_EN
        logic                sub_prev;
`endif

        if (g == 0) begin : g_first
            assign v_prev = in_valid;
            assign a_prev = in_a;
            assign b_prev = in_b;
`ifdef PIPE_ADDER_SUB_EN
            assign sub_prev = in_sub;
            // Subtract is A + ~B + 1, so the +1 replaces the caller's carry-in.
            assign c_prev   = in_sub | in_cin;
`else
            assign c_prev   = in_cin;
`endif
            assign sum_d  = s_sum;
        end else begin : g_next
            assign v_prev = g_stage[g-1].v_q;
            assign a_prev = g_stage[g-1].g_carry.a_q;
            assign b_prev = g_stage[g-1].g_carry.b_q;
`ifdef PIPE_ADDER_SUB_EN
            assign sub_prev = g_stage[g-1].g_carry.sub_q;
`endif
            assign c_prev = g_stage[g-1].c_q;
            assign sum_d  = {s_sum, g_stage[g-1].sum_q};
        end

`ifdef PIPE_ADDER_SUB_EN
        assign b_eff = b_prev[SW-1:0] ^ {SW{sub_prev}};
`else
        assign b_eff = b_prev[SW-1:0];
`endif

        adder_slice #(.W(SW)) u_slice (
            .a_i   (a_prev[SW-1:0]),
            .b_i   (b_eff),
            .cin_i (c_prev),
            .sum_o (s_sum),
            .cout_o(s_cout)
        );

        // A stage may load when it is empty or its content moves on this cycle.
        assign rdy = !v_q | rdy_next;

        if (g == STAGES - 1) begin : g_last
            assign rdy_next = out_ready;
        end else begin : g_carry
            // Upper operand slices still waiting to be added further down the pipe.
            localparam int RW = IW - SW;
            logic [RW-1:0] a_q;
            logic [RW-1:0] b_q;
`ifdef PIPE_ADDER_SUB_EN
            logic          sub_q;
`endif

            assign rdy_next = g_stage[g+1].rdy;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q   <= '0;
                    b_q   <= '0;
`ifdef PIPE_ADDER_SUB_EN
                    sub_q <= 1'b0;
`endif
                end else if (rdy) begin
                    a_q   <= a_prev[IW-1:SW];
                    b_q   <= b_prev[IW-1:SW];
`ifdef PIPE_ADDER_SUB_EN
                    sub_q <= sub_prev;
`endif
                end
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q   <= 1'b0;
                sum_q <= '0;
                c_q   <= 1'b0;
            end else if (rdy) begin
                v_q   <= v_prev;
                sum_q <= sum_d;
                c_q   <= s_cout;
            end
        end
    end

    assign in_ready  = g_stage[0].rdy;
    assign out_valid = g_stage[STAGES-1].v_q;
    assign out_sum   = g_stage[STAGES-1].sum_q;
    assign out_cout  = g_stage[STAGES-1].c_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (default 16/4 instance plus a 4/1 instance).
// Latency: n/a.
// Backpressure: out_ready driven directly and randomly by the bench.
module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        in_valid, in_ready, in_cin, in_sub;
    logic [15:0] in_a, in_b, out_sum;
    logic        out_valid, out_ready, out_cout;

    // WIDTH=4, STAGES=1 instance
    logic        s_in_valid, s_in_ready, s_cin, s_out_valid, s_out_ready, s_cout, s_sub;
    logic [3:0]  s_a, s_b, s_sum;

    pipelined_adder dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
`ifdef PIPE_ADDER_SUB_EN
        .in_sub(in_sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout)
    );

    pipelined_adder #(.WIDTH(4), .STAGES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_a), .in_b(s_b), .in_cin(s_cin),
`ifdef PIPE_ADDER_SUB_EN
        .in_sub(s_sub),
`endif
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_sum(s_sum), .out_cout(s_cout)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    int          n_in = 0;
    int          n_out = 0;
    bit          auto_push = 1'b0;
    bit          hold_pend = 1'b0;
    logic [16:0] hold_val = '0;
    logic [16:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the true sum as an integer; bit 16 is the carry-out.
    // Subtraction is A - B + 2^16, whose bit 16 is set exactly when no borrow occurs.
    function automatic logic [16:0] ref_sum(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin, input logic sub);
        int unsigned x;
        if (sub) x = int'(a) - int'(b) + 65536;
        else     x = int'(a) + int'(b) + int'(cin);
        return x[16:0];
    endfunction

    // One cycle of bookkeeping: inputs were set at posedge+1, sampled here at +2.
    task automatic tick();
        logic [16:0] e;
        #1;
        if (hold_pend) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'({out_cout, out_sum}), 32'(hold_val));
        end
        if (out_valid && out_ready) begin
            check("out_has_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("result", 32'({out_cout, out_sum}), 32'(e));
                n_out++;
            end
        end
        hold_pend = out_valid && !out_ready;
        hold_val  = {out_cout, out_sum};
        if (in_valid && in_ready) begin
            n_in++;
            if (auto_push) exp_q.push_back(ref_sum(in_a, in_b, in_cin, in_sub));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) tick();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic rand_beat();
        in_a   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        in_b   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        in_cin = 1'($urandom);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int in0;
        int out0;

        // ---------------- reset state ----------------
        rst_n = 1'b0;
        in_valid = 0; in_a = 0; in_b = 0; in_cin = 0; in_sub = 0; out_ready = 0;
        s_in_valid = 0; s_a = 0; s_b = 0; s_cin = 0; s_sub = 0; s_out_ready = 0;
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum", 32'(out_sum), 32'd0);
        check("rst_out_cout", 32'(out_cout), 32'd0);
        check("rst_s_out_valid", 32'(s_out_valid), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_s_in_ready", 32'(s_in_ready), 32'd1);
        @(posedge clk);
        #1;

        // ---------------- 4-bit single-stage adder ----------------
        s_in_valid = 1; s_a = 4'b1101; s_b = 4'b0101; s_cin = 0;
        #1;
        check("w4_in_ready", 32'(s_in_ready), 32'd1);
        @(posedge clk);
        #1;
        s_in_valid = 0;
        check("w4_out_valid", 32'(s_out_valid), 32'd1);
        check("w4_sum", 32'(s_sum), 32'h2);
        check("w4_cout", 32'(s_cout), 32'd1);
        s_out_ready = 1;
        @(posedge clk);
        #1;
        check("w4_consumed", 32'(s_out_valid), 32'd0);

        // ---------------- carry across all slices + latency ----------------
        auto_push = 0;
        exp_q.push_back(17'h1_0000);
        out_ready = 1;
        in_valid = 1; in_a = 16'hFFFF; in_b = 16'h0000; in_cin = 1;
        tick();
        in_valid = 0;
        lat = 0;
        for (int i = 1; i <= 10; i++) begin
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
            @(posedge clk);
        end
        check("latency", 32'(lat), 32'd4);
        drain();

        // ---------------- random stream with random back-pressure ----------------
        auto_push = 1;
        in0 = n_in;
        out0 = n_out;
        for (int cyc = 0; cyc < 3000 && ((n_in - in0) < 100 || exp_q.size() > 0); cyc++) begin
            in_valid = ((n_in - in0) < 100) && ($urandom_range(0, 3) != 0);
            rand_beat();
`ifdef PIPE_ADDER_SUB_EN
            in_sub = 1'($urandom);
`endif
            out_ready = 1'($urandom);
            tick();
        end
        in_sub = 0;
        check("rand_accepted", 32'(n_in - in0), 32'd100);
        check("rand_delivered", 32'(n_out - out0), 32'd100);
        drain();

        // ---------------- fill with stalled output, then full throughput ----------------
        out_ready = 0;
        in_valid = 1;
        in0 = n_in;
        for (int i = 0; i < 4; i++) begin
            rand_beat();
            #1;
            check("fill_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        rand_beat();
        #1;
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_accepted", 32'(n_in - in0), 32'd4);
        tick();
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            rand_beat();
            #1;
            check("stream_in_ready", 32'(in_ready), 32'd1);
            check("stream_out_valid", 32'(out_valid), 32'd1);
            tick();
        end
        drain();

        // ---------------- reset with beats in flight ----------------
        out_ready = 0;
        in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            rand_beat();
            tick();
        end
        in_valid = 0;
        tick();
        check("pre_rst_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_sum", 32'(out_sum), 32'd0);
        check("midrst_out_cout", 32'(out_cout), 32'd0);
        exp_q.delete();
        hold_pend = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("no_stale_out", 32'(out_valid), 32'd0);
            tick();
        end

`ifdef PIPE_ADDER_SUB_EN
        // ---------------- subtract mode ----------------
        auto_push = 0;
        exp_q.push_back(17'h0_FFFE);
        exp_q.push_back(17'h1_0002);
        in_valid = 1; in_sub = 1;
        in_a = 16'h0005; in_b = 16'h0007; in_cin = 1;
        tick();
        in_a = 16'h0007; in_b = 16'h0005; in_cin = 0;
        tick();
        in_sub = 0;
        drain();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
